// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register map and width limit.
package gpio_pkg;

  localparam int unsigned GPIO_MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    GPIO_DATA = 3'd0,
    GPIO_DIR  = 3'd1,
    GPIO_SET  = 3'd2,
    GPIO_CLR  = 3'd3,
    GPIO_TGL  = 3'd4,
    GPIO_RISE = 3'd5,
    GPIO_FALL = 3'd6,
    GPIO_PEND = 3'd7
  } gpio_reg_e;

endpackage

// File: rtl/gpio_sync.sv
// Input synchroniser, previous-sample register and post-reset arming for edge detection.
module gpio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise_raw,
  output logic [WIDTH-1:0] fall_raw
);

  localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prev;
  logic [2:0]                        arm_cnt;
  logic                              armed;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      chain   <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin_in};
      prev  <= chain[SYNC_STAGES-1];
      if (!armed)
        arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign sync  = chain[SYNC_STAGES-1];
  // Held off until the chain and prev hold real samples, so pins high at reset don't look like rises.
  assign armed = (arm_cnt == ARM_COUNT);

  assign rise_raw = sync & ~prev & {WIDTH{armed}};
  assign fall_raw = ~sync & prev & {WIDTH{armed}};

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: output/direction registers, atomic set/clear/toggle, edge-detect interrupts.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             sel,
  input  logic             rd,
  input  logic             wr,
  input  logic [2:0]       addr,
  input  logic [15:0]      wd,
  output logic [15:0]      rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, dir_q, rise_en, fall_en, pend;
  logic [WIDTH-1:0] sync, rise_raw, fall_raw;
  logic [WIDTH-1:0] wd_w, clr_mask, pend_next, rd_w;
  logic [15:0]      rdata_ext;
  logic             we;
  gpio_reg_e        reg_sel;
  logic             unused_bits;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .resetq   (resetq),
    .pin_in   (pin_in),
    .sync     (sync),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  assign wd_w        = wd[WIDTH-1:0];
  assign we          = sel & wr;
  assign reg_sel     = gpio_reg_e'(addr);
  assign unused_bits = ^{rd, wd};

  // Enables are the pre-write values, and a new edge overrides a same-cycle W1C.
  always_comb begin
    clr_mask = '0;
    if (we && reg_sel == GPIO_PEND)
      clr_mask = wd_w;
    pend_next = (pend & ~clr_mask) | (rise_raw & rise_en) | (fall_raw & fall_en);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      out_q   <= OUT_RESET;
      dir_q   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
    end else begin
      if (we) begin
        case (reg_sel)
          GPIO_DATA: out_q   <= wd_w;
          GPIO_DIR:  dir_q   <= wd_w;
          GPIO_SET:  out_q   <= out_q | wd_w;
          GPIO_CLR:  out_q   <= out_q & ~wd_w;
          GPIO_TGL:  out_q   <= out_q ^ wd_w;
          GPIO_RISE: rise_en <= wd_w;
          GPIO_FALL: fall_en <= wd_w;
          default:   ;
        endcase
      end
      pend <= pend_next;
    end
  end

  always_comb begin
    rd_w = '0;
    case (reg_sel)
      GPIO_DATA: rd_w = sync;
      GPIO_DIR:  rd_w = dir_q;
      GPIO_SET,
      GPIO_CLR,
      GPIO_TGL:  rd_w = out_q;
      GPIO_RISE: rd_w = rise_en;
      GPIO_FALL: rd_w = fall_en;
      GPIO_PEND: rd_w = pend;
      default:   rd_w = '0;
    endcase
    rdata_ext = '0;
    if (sel)
      rdata_ext[WIDTH-1:0] = rd_w;
  end

  assign rdata   = rdata_ext;
  assign pin_out = out_q;
  assign pin_oe  = dir_q;
  assign irq     = |pend;

endmodule
